// File: rtl/symbol_serializer.sv
// Frame-buffering symbol serializer: queues 4-symbol frames and streams each
// symbol for SPS cycles with registered sof/eof markers and sticky overflow.
module symbol_serializer #(
  parameter int unsigned       SYM_W      = 8,
  parameter int unsigned       SPS        = 4,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter logic [SYM_W-1:0]  IDLE_LEVEL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    in_valid_i,
  input  logic [3:0][SYM_W-1:0]   in_sym_i,
  output logic                    in_ready_o,
  output logic [SYM_W-1:0]        tx_sample_o,
  output logic                    tx_valid_o,
  output logic                    tx_sof_o,
  output logic                    tx_eof_o,
  output logic                    overflow_o,
  output logic                    busy_o
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SPS - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  logic [3:0][SYM_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  full, empty, push, pop;

  state_e                state_q, state_d;
  logic [3:0][SYM_W-1:0] frame_q, frame_d;
  logic [1:0]            sym_idx_q, sym_idx_d;
  logic [CNT_W-1:0]      samp_cnt_q, samp_cnt_d;
  logic [SYM_W-1:0]      tx_sample_q, tx_sample_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_sof_q, tx_sof_d;
  logic                  tx_eof_q, tx_eof_d;
  logic                  overflow_q, overflow_d;
  logic                  samp_wrap, frame_end;

  // Extra pointer MSB distinguishes full from empty when addresses match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_valid_i && !full;

  assign wr_ptr_d   = push ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
  assign rd_ptr_d   = pop  ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
  assign overflow_d = overflow_q || (in_valid_i && full);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= in_sym_i;
    end
  end

  assign samp_wrap = (samp_cnt_q == SAMP_LAST);
  assign frame_end = samp_wrap && (sym_idx_q == 2'd3);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_i && !empty) state_d = ST_SEND;
      ST_SEND: if (en_i && frame_end && empty) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic; tx_* values here land in registers at the edge.
  always_comb begin
    pop         = 1'b0;
    sym_idx_d   = sym_idx_q;
    samp_cnt_d  = samp_cnt_q;
    tx_valid_d  = 1'b0;
    tx_sample_d = IDLE_LEVEL;
    tx_sof_d    = 1'b0;
    tx_eof_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i && !empty) begin
          pop        = 1'b1;
          sym_idx_d  = 2'd0;
          samp_cnt_d = '0;
        end
      end
      ST_SEND: begin
        if (en_i) begin
          tx_valid_d  = 1'b1;
          tx_sample_d = frame_q[sym_idx_q];
          tx_sof_d    = (sym_idx_q == 2'd0) && (samp_cnt_q == '0);
          tx_eof_d    = frame_end;
          if (samp_wrap) begin
            samp_cnt_d = '0;
            sym_idx_d  = sym_idx_q + 2'd1;
          end else begin
            samp_cnt_d = samp_cnt_q + CNT_W'(1);
          end
          // Chain the next frame with no gap; counters already wrap to zero.
          if (frame_end && !empty) pop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign frame_d = pop ? fifo_mem[rd_ptr_q[AW-1:0]] : frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_q     <= '0;
      sym_idx_q   <= 2'd0;
      samp_cnt_q  <= '0;
      tx_sample_q <= IDLE_LEVEL;
      tx_valid_q  <= 1'b0;
      tx_sof_q    <= 1'b0;
      tx_eof_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_q     <= frame_d;
      sym_idx_q   <= sym_idx_d;
      samp_cnt_q  <= samp_cnt_d;
      tx_sample_q <= tx_sample_d;
      tx_valid_q  <= tx_valid_d;
      tx_sof_q    <= tx_sof_d;
      tx_eof_q    <= tx_eof_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready_o  = !full;
  assign busy_o      = (state_q == ST_SEND) || !empty;
  assign tx_sample_o = tx_sample_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_sof_o    = tx_sof_q;
  assign tx_eof_o    = tx_eof_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_symbol_serializer.sv
// Scoreboard bench for symbol_serializer: an SPS=4 instance for the main
// scenarios and an SPS=1 instance for the single-sample-per-symbol build.
module tb_symbol_serializer;

  localparam int SYM_W = 8;
  localparam int SPS0  = 4;
  localparam int SPS1  = 1;

  typedef struct packed {
    logic [7:0] s;
    logic       sof;
    logic       eof;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            en, in_valid, in_ready, tx_valid, tx_sof, tx_eof, overflow, busy;
  logic [3:0][7:0] in_sym;
  logic [7:0]      tx_sample;

  logic            en1, in_valid1, in_ready1, tx_valid1, tx_sof1, tx_eof1, overflow1, busy1;
  logic [3:0][7:0] in_sym1;
  logic [7:0]      tx_sample1;

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_cmp = 0;
  int   n_err = 0;

  symbol_serializer #(.SYM_W(SYM_W), .SPS(SPS0), .FIFO_DEPTH(2), .IDLE_LEVEL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .in_valid_i(in_valid), .in_sym_i(in_sym),
    .in_ready_o(in_ready), .tx_sample_o(tx_sample), .tx_valid_o(tx_valid),
    .tx_sof_o(tx_sof), .tx_eof_o(tx_eof), .overflow_o(overflow), .busy_o(busy)
  );

  symbol_serializer #(.SYM_W(SYM_W), .SPS(SPS1), .FIFO_DEPTH(2), .IDLE_LEVEL(8'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_i(en1), .in_valid_i(in_valid1), .in_sym_i(in_sym1),
    .in_ready_o(in_ready1), .tx_sample_o(tx_sample1), .tx_valid_o(tx_valid1),
    .tx_sof_o(tx_sof1), .tx_eof_o(tx_eof1), .overflow_o(overflow1), .busy_o(busy1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input int which, input logic [3:0][7:0] syms);
    int   sps;
    exp_t e;
    sps = (which == 0) ? SPS0 : SPS1;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < sps; k++) begin
        e.s   = syms[j];
        e.sof = (j == 0) && (k == 0);
        e.eof = (j == 3) && (k == sps - 1);
        if (which == 0) sb0.push_back(e);
        else            sb1.push_back(e);
      end
    end
  endtask

  task automatic push0(input logic [3:0][7:0] syms, input logic acc);
    @(negedge clk);
    in_sym   = syms;
    in_valid = 1'b1;
    check("in_ready0", 32'(in_ready), 32'(acc));
    if (acc) expect_frame(0, syms);
    $display("push0 %h %h %h %h accept=%0d", syms[0], syms[1], syms[2], syms[3], acc);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic push1(input logic [3:0][7:0] syms);
    @(negedge clk);
    in_sym1   = syms;
    in_valid1 = 1'b1;
    check("in_ready1", 32'(in_ready1), 32'd1);
    expect_frame(1, syms);
    $display("push1 %h %h %h %h", syms[0], syms[1], syms[2], syms[3]);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
  endtask

  // Watches dut until its stream goes quiet, optionally pulling en low mid-frame.
  task automatic measure0(input int max_cyc, input int gap_at, input int gap_len,
                          output int cnt, output int first_i, output int span,
                          output bit timed_out);
    int last_i;
    bit gapped;
    int gap_left;
    bit done;
    cnt = 0; first_i = -1; last_i = -1; gapped = 0; gap_left = 0; done = 0; timed_out = 1;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        cnt++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) en = 1'b1;
      end else if (gap_at > 0 && !gapped && cnt == gap_at) begin
        en = 1'b0;
        gapped = 1;
        gap_left = gap_len;
      end
      if (cnt > 0 && !tx_valid && !busy) begin
        done = 1;
        timed_out = 0;
      end
    end
    span = (first_i < 0) ? 0 : (last_i - first_i + 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (tx_valid) begin
        if (sb0.size() == 0) begin
          check("sb0_unexpected_sample", 32'(sb0.size()), 32'd1);
        end else begin
          e = sb0.pop_front();
          check("sb0_sample", 32'({tx_sample, tx_sof, tx_eof}), 32'(e));
        end
      end else begin
        check("idle0", 32'({tx_sample, tx_sof, tx_eof}), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (tx_valid1) begin
        if (sb1.size() == 0) begin
          check("sb1_unexpected_sample", 32'(sb1.size()), 32'd1);
        end else begin
          e = sb1.pop_front();
          check("sb1_sample", 32'({tx_sample1, tx_sof1, tx_eof1}), 32'(e));
        end
      end else begin
        check("idle1", 32'({tx_sample1, tx_sof1, tx_eof1}), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt, first_i, span, sof_i, eof_i;
    bit  to;
    logic [3:0][7:0] fa, fb, fc;

    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_sym = '0;
    en1 = 1'b1; in_valid1 = 1'b0; in_sym1 = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_sample", 32'(tx_sample), 32'd0);
    check("rst_sof_eof", 32'({tx_sof, tx_eof}), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (2) @(negedge clk);

    // T1 single frame
    fa = {8'h44, 8'h33, 8'h22, 8'h11};
    push0(fa, 1'b1);
    measure0(60, 0, 0, cnt, first_i, span, to);
    check("t1_timeout", 32'(to), 32'd0);
    check("t1_latency", 32'(first_i), 32'd2);
    check("t1_count", 32'(cnt), 32'd16);
    check("t1_contig", 32'(span), 32'd16);

    // T2 back-to-back frames
    fa = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
    fb = {8'hB4, 8'hB3, 8'hB2, 8'hB1};
    push0(fa, 1'b1);
    push0(fb, 1'b1);
    check("t2_busy_mid", 32'(busy), 32'd1);
    measure0(100, 0, 0, cnt, first_i, span, to);
    check("t2_timeout", 32'(to), 32'd0);
    check("t2_count", 32'(cnt), 32'd32);
    check("t2_contig", 32'(span), 32'd32);
    check("t2_busy_end", 32'(busy), 32'd0);

    // T3 overflow with output frozen
    @(negedge clk);
    en = 1'b0;
    check("t3_ovf_before", 32'(overflow), 32'd0);
    fa = {8'h14, 8'h13, 8'h12, 8'h11};
    fb = {8'h24, 8'h23, 8'h22, 8'h21};
    fc = {8'h34, 8'h33, 8'h32, 8'h31};
    push0(fa, 1'b1);
    push0(fb, 1'b1);
    push0(fc, 1'b0);
    check("t3_in_ready_full", 32'(in_ready), 32'd0);
    check("t3_overflow_set", 32'(overflow), 32'd1);
    check("t3_no_output_when_disabled", 32'(tx_valid), 32'd0);
    en = 1'b1;
    measure0(100, 0, 0, cnt, first_i, span, to);
    check("t3_timeout", 32'(to), 32'd0);
    check("t3_count", 32'(cnt), 32'd32);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    check("t3_in_ready_after", 32'(in_ready), 32'd1);

    // T4 enable gap after the 6th sample
    fa = {8'h5D, 8'h5C, 8'h5B, 8'h5A};
    push0(fa, 1'b1);
    measure0(80, 6, 3, cnt, first_i, span, to);
    check("t4_timeout", 32'(to), 32'd0);
    check("t4_count", 32'(cnt), 32'd16);
    check("t4_gap_cycles", 32'(span - cnt), 32'd3);

    // T5 asynchronous reset mid-frame
    fa = {8'h6D, 8'h6C, 8'h6B, 8'h6A};
    push0(fa, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 9; i++) begin
      @(negedge clk);
      if (tx_valid) cnt++;
    end
    check("t5_reach_sample9", 32'(cnt), 32'd9);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(tx_valid), 32'd0);
    check("t5_rst_sample", 32'(tx_sample), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_overflow", 32'(overflow), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    sb0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    measure0(20, 0, 0, cnt, first_i, span, to);
    check("t5_no_output_after", 32'(cnt), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);

    // T6 SPS=1 instance
    fa = {8'h04, 8'h03, 8'h02, 8'h01};
    push1(fa);
    cnt = 0; sof_i = -1; eof_i = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid1) cnt++;
      if (tx_sof1) sof_i = i;
      if (tx_eof1) eof_i = i;
    end
    check("t6_count", 32'(cnt), 32'd4);
    check("t6_sof_eof_dist", 32'(eof_i - sof_i), 32'd3);
    check("t6_busy_end", 32'(busy1), 32'd0);

    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
